axi_stream_cache_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one AXI-stream cache/FIFO write port between NUM upstream requesters.
- Once granted, a requester holds the port until its tlast beat is accepted.
- A 2-entry skid buffer registers the output side, so the downstream cache input sees registered tvalid/tdata/tlast/tid.
- The block sits directly in front of the stream cache and supplies the source index with each beat.

---
 rtl/axi_stream_cache_packet_arbiter_if.sv | 29 ++
 rtl/axi_stream_cache_packet_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_stream_cache_packet_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_cache_packet_arbiter_if.sv
// AXI-stream bundle with N parallel lanes sharing one tid field.
// The upstream side uses N=NUM lanes; the cache side uses a single lane.
interface axi_stream_cache_packet_arbiter_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 1
);
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tready;
  logic [IW-1:0]   tid;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tid,
    output tready
  );
endinterface

// File: rtl/axi_stream_cache_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-stream cache write port
// through a 2-entry skid buffer, tagging every beat with its source index.
module axi_stream_cache_packet_arbiter #(
  parameter int unsigned NUM   = 4,
  parameter int unsigned DSIZE = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi_stream_cache_packet_arbiter_if.slave  s_axis,
  axi_stream_cache_packet_arbiter_if.master m_axis,
  output logic                          grant_vld,
  output logic [$clog2(NUM)-1:0]        grant_id
);

  localparam int unsigned IDSIZE = $clog2(NUM);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  typedef struct packed {
    logic              last;
    logic [IDSIZE-1:0] id;
    logic [DSIZE-1:0]  data;
  } beat_t;

  state_e            state_q, state_d;
  logic [IDSIZE-1:0] ptr_q, ptr_d;
  logic [IDSIZE-1:0] gid_q, gid_d;
  logic              gvld_q, gvld_d;

  beat_t head_q, head_d;
  beat_t tail_q, tail_d;
  logic  head_vld_q, head_vld_d;
  logic  tail_vld_q, tail_vld_d;

  logic [DSIZE-1:0]  lane_data [NUM];
  logic [IDSIZE-1:0] winner;
  logic              found;
  logic [IDSIZE-1:0] idx;
  logic              accept;
  logic              pop;
  beat_t             in_beat;

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    assign lane_data[g] = s_axis.tdata[g*DSIZE +: DSIZE];
  end

  // Round-robin search starting at the priority pointer.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM; k++) begin
      idx = IDSIZE'((32'(ptr_q) + 32'(k)) % NUM);
      if (!found && s_axis.tvalid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Ready only reflects registered state: locked and tail slot free.
  always_comb begin
    s_axis.tready = '0;
    if (state_q == StLock && !tail_vld_q) begin
      s_axis.tready[gid_q] = 1'b1;
    end
  end

  assign accept  = (state_q == StLock) && !tail_vld_q && s_axis.tvalid[gid_q];
  assign pop     = head_vld_q && m_axis.tready;
  assign in_beat = '{last: s_axis.tlast[gid_q], id: gid_q, data: lane_data[gid_q]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gvld_d  = gvld_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gid_d   = winner;
          gvld_d  = 1'b1;
          state_d = StLock;
        end
      end
      StLock: begin
        if (accept && s_axis.tlast[gid_q]) begin
          ptr_d   = (gid_q == IDSIZE'(NUM - 1)) ? '0 : gid_q + IDSIZE'(1);
          gvld_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: pop first, then push into the lowest free slot so order holds.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end
    if (accept) begin
      if (!head_vld_d) begin
        head_d     = in_beat;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = in_beat;
        tail_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gid_q      <= '0;
      gvld_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      gvld_q     <= gvld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign m_axis.tvalid = head_vld_q;
  assign m_axis.tdata  = head_q.data;
  assign m_axis.tlast  = head_q.last;
  assign m_axis.tid    = head_q.id;
  assign grant_vld     = gvld_q;
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_axi_stream_cache_packet_arbiter.sv
// Directed bench for the packet arbiter: per-lane packet sources, output capture,
// immediate assertions against hand-derived expectations.
module tb_axi_stream_cache_packet_arbiter;
  localparam int unsigned NUM    = 4;
  localparam int unsigned DSIZE  = 32;
  localparam int unsigned IDSIZE = $clog2(NUM);

  typedef struct packed {
    logic [IDSIZE-1:0] id;
    logic              last;
    logic [DSIZE-1:0]  data;
  } obeat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic              grant_vld;
  logic [IDSIZE-1:0] grant_id;

  axi_stream_cache_packet_arbiter_if #(.N(NUM), .DW(DSIZE), .IW(IDSIZE)) s_if ();
  axi_stream_cache_packet_arbiter_if #(.N(1),   .DW(DSIZE), .IW(IDSIZE)) m_if ();

  axi_stream_cache_packet_arbiter #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 aclk = ~aclk;

  initial assert ($bits(m_if.tdata) == DSIZE)
    else $fatal(1, "FAIL dsize width=%0d need=%0d", $bits(m_if.tdata), DSIZE);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DSIZE-1:0] ldata [NUM];
  int               lbeat [NUM];
  int               llen  [NUM];
  int               lpkts [NUM];
  logic             lhold [NUM];
  int               accn  [NUM];
  obeat_t           outq [$];
  int               accq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
  endtask

  function automatic obeat_t mk(input int id, input logic last, input logic [DSIZE-1:0] d);
    return {IDSIZE'(id), last, d};
  endfunction

  task automatic chk_beat(input string tag, input int k, input obeat_t exp);
    logic [63:0] got;
    got = (k < outq.size()) ? 64'(outq[k]) : 'x;
    chk(tag, got, 64'(exp));
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      s_if.tvalid[i] = (lpkts[i] > 0) && !lhold[i];
      s_if.tlast[i]  = (lbeat[i] == llen[i] - 1);
      s_if.tdata[i*DSIZE +: DSIZE] = ldata[i];
    end
  endtask

  // Sample handshakes in the stable window before the edge, then advance sources.
  task automatic tick();
    logic [NUM-1:0] acc;
    acc = s_if.tvalid & s_if.tready;
    if (m_if.tvalid[0] && m_if.tready[0]) outq.push_back({m_if.tid, m_if.tlast[0], m_if.tdata});
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < NUM; i++) begin
      if (acc[i]) begin
        accn[i]++;
        accq.push_back(cyc);
        ldata[i] = ldata[i] + 1;
        lbeat[i] = lbeat[i] + 1;
        if (lbeat[i] == llen[i]) begin
          lbeat[i] = 0;
          lpkts[i] = lpkts[i] - 1;
        end
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM; i++) begin
      ldata[i] = '0; lbeat[i] = 0; llen[i] = 1; lpkts[i] = 0; lhold[i] = 1'b0; accn[i] = 0;
    end
    outq.delete();
    accq.delete();
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    clear_all();
    m_if.tready = 1'b1;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic lane(input int i, input logic [DSIZE-1:0] base, input int len, input int pkts);
    ldata[i] = base; llen[i] = len; lpkts[i] = pkts; lbeat[i] = 0;
  endtask

  int seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    s_if.tid = '0;
    clear_all();
    m_if.tready = 1'b0;
    drive();
    #1;
    // Reset state
    chk("rst m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst m_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst m_tid", 64'(m_if.tid), 64'd0);
    chk("rst s_tready", 64'(s_if.tready), 64'd0);
    chk("rst grant_vld", 64'(grant_vld), 64'd0);
    chk("rst grant_id", 64'(grant_id), 64'd0);
    apply_reset();

    // Single requester, 4-beat packet
    lane(2, 32'hA0, 4, 1);
    drive();
    tick();
    chk("t1 grant_vld", 64'(grant_vld), 64'd1);
    chk("t1 grant_id", 64'(grant_id), 64'd2);
    chk("t1 s_tready", 64'(s_if.tready), 64'b0100);
    tick();
    chk("t1 head data", 64'(m_if.tdata), 64'hA0);
    chk("t1 head tid", 64'(m_if.tid), 64'd2);
    run(2);
    chk("t1 lock held", 64'(grant_vld), 64'd1);
    tick();
    chk("t1 grant drop", 64'(grant_vld), 64'd0);
    run(4);
    chk("t1 count", 64'(outq.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk_beat("t1 beat", k, mk(2, k == 3, 32'hA0 + k));

    // All four requesters, rotating grants with a bubble per boundary
    apply_reset();
    lane(0, 32'h0000, 3, 2);
    lane(1, 32'h1000, 3, 2);
    lane(2, 32'h2000, 3, 1);
    lane(3, 32'h3000, 3, 1);
    drive();
    run(30);
    chk("t2 count", 64'(outq.size()), 64'd18);
    for (int p = 0; p < 6; p++) begin
      for (int b = 0; b < 3; b++) begin
        chk_beat("t2 beat", 3*p + b,
                 mk(seq[p], b == 2, DSIZE'(seq[p] * 32'h1000 + (p / 4) * 3 + b)));
      end
    end
    chk("t2 back2back", 64'(accq.size() > 3 ? accq[1] - accq[0] : -1), 64'd1);
    chk("t2 bubble", 64'(accq.size() > 3 ? accq[3] - accq[2] : -1), 64'd2);

    // Pointer wrap: pointer at 2, lanes 3,0,1 pending -> 3,0,1
    clear_all();
    lane(3, 32'h3300, 2, 1);
    lane(0, 32'h3000, 2, 1);
    lane(1, 32'h3100, 2, 1);
    drive();
    tick();
    chk("t3 first grant", 64'(grant_id), 64'd3);
    run(20);
    chk("t3 count", 64'(outq.size()), 64'd6);
    chk_beat("t3 pkt0", 0, mk(3, 1'b0, 32'h3300));
    chk_beat("t3 pkt1", 2, mk(0, 1'b0, 32'h3000));
    chk_beat("t3 pkt2", 4, mk(1, 1'b0, 32'h3100));

    // Backpressure on an 8-beat packet
    clear_all();
    m_if.tready = 1'b0;
    lane(2, 32'hB0, 8, 1);
    drive();
    tick();
    run(3);
    chk("t4 stable data a", 64'(m_if.tdata), 64'hB0);
    run(7);
    chk("t4 accepted", 64'(accn[2]), 64'd2);
    chk("t4 s_tready low", 64'(s_if.tready), 64'd0);
    chk("t4 m_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("t4 stable data b", 64'(m_if.tdata), 64'hB0);
    chk("t4 stable tid", 64'(m_if.tid), 64'd2);
    m_if.tready = 1'b1;
    tick();
    chk("t4 ready back", 64'(s_if.tready), 64'b0100);
    chk("t4 next head", 64'(m_if.tdata), 64'hB1);
    run(15);
    chk("t4 count", 64'(outq.size()), 64'd8);
    for (int k = 0; k < 8; k++) chk_beat("t4 beat", k, mk(2, k == 7, 32'hB0 + k));

    // Single-beat packets from lanes 0 and 1 under random backpressure
    clear_all();
    lane(0, 32'hC0, 1, 3);
    lane(1, 32'hD0, 1, 3);
    drive();
    for (int i = 0; i < 40; i++) begin
      m_if.tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_if.tready = 1'b1;
    run(10);
    chk("t5 count", 64'(outq.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk_beat("t5 beat", k, mk(k % 2, 1'b1, DSIZE'((k % 2 == 0 ? 32'hC0 : 32'hD0) + k / 2)));
    end

    // Reset in the middle of a 5-beat packet from lane 3
    clear_all();
    lane(3, 32'hE0, 5, 1);
    drive();
    tick();
    chk("t6 grant 3", 64'(grant_id), 64'd3);
    run(3);
    chk("t6 busy", 64'(m_if.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t6 rst m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t6 rst s_tready", 64'(s_if.tready), 64'd0);
    chk("t6 rst grant_vld", 64'(grant_vld), 64'd0);
    lane(0, 32'hF0, 1, 1);
    drive();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    chk("t6 post grant_vld", 64'(grant_vld), 64'd1);
    chk("t6 post grant_id", 64'(grant_id), 64'd0);

    // Granted lane drops valid mid-packet: lock is kept
    apply_reset();
    lane(0, 32'h70, 4, 1);
    lane(1, 32'h80, 1, 1);
    drive();
    run(3);
    lhold[0] = 1'b1;
    drive();
    run(3);
    chk("t7 hold grant_id", 64'(grant_id), 64'd0);
    chk("t7 hold grant_vld", 64'(grant_vld), 64'd1);
    chk("t7 hold s_tready", 64'(s_if.tready), 64'b0001);
    lhold[0] = 1'b0;
    drive();
    run(15);
    chk("t7 count", 64'(outq.size()), 64'd5);
    chk_beat("t7 last of 0", 3, mk(0, 1'b1, 32'h73));
    chk_beat("t7 lane 1", 4, mk(1, 1'b1, 32'h80));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
